// File: rtl/hb_pkg.sv
// Shared definitions for the Hummingbird 16-bit block decryptor:
// round count, FSM state type, key slice positions and inverse S-box tables.
package hb_pkg;

  localparam int HB_ROUNDS = 4;
  localparam int RND_W     = 2;
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(HB_ROUNDS - 1);

  localparam int BLK_W  = 16;
  localparam int K1_LSB = 0;
  localparam int K2_LSB = 16;
  localparam int K3_LSB = 32;
  localparam int K4_LSB = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } hb_state_e;

  // Inverse S-boxes; entry i is the nibble that the forward box maps to i.
  localparam logic [3:0] S1_INV [16] = '{
    4'hD, 4'h4, 4'hA, 4'hF, 4'hB, 4'h2, 4'h1, 4'hC,
    4'h0, 4'h7, 4'h6, 4'h9, 4'h5, 4'hE, 4'h8, 4'h3};
  localparam logic [3:0] S2_INV [16] = '{
    4'h0, 4'h3, 4'h7, 4'h8, 4'hE, 4'h4, 4'hB, 4'h1,
    4'h6, 4'hF, 4'h9, 4'h5, 4'hD, 4'hA, 4'h2, 4'hC};
  localparam logic [3:0] S3_INV [16] = '{
    4'hC, 4'h3, 4'h0, 4'hA, 4'hB, 4'h4, 4'h5, 4'hF,
    4'h9, 4'hE, 4'h6, 4'hD, 4'h2, 4'h7, 4'h8, 4'h1};
  localparam logic [3:0] S4_INV [16] = '{
    4'hA, 4'h7, 4'h6, 4'h9, 4'h1, 4'h2, 4'hC, 4'h5,
    4'h3, 4'h4, 4'h8, 4'hF, 4'hD, 4'hE, 4'hB, 4'h0};

  // Extract one 16-bit subkey from the 64-bit key.
  function automatic logic [BLK_W-1:0] key_word(input logic [63:0] key, input int lsb);
    return key[lsb +: BLK_W];
  endfunction

endpackage

// File: rtl/S1_box_dec.sv
// Inverse of S-box 1 (applied to plaintext-side nibble [15:12]).
module S1_box_dec
  import hb_pkg::*;
(
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);
  assign nib_out = S1_INV[nib_in];
endmodule

// File: rtl/S2_box_dec.sv
// Inverse of S-box 2 (nibble [11:8]).
module S2_box_dec
  import hb_pkg::*;
(
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);
  assign nib_out = S2_INV[nib_in];
endmodule

// File: rtl/S3_box_dec.sv
// Inverse of S-box 3 (nibble [7:4]).
module S3_box_dec
  import hb_pkg::*;
(
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);
  assign nib_out = S3_INV[nib_in];
endmodule

// File: rtl/S4_box_dec.sv
// Inverse of S-box 4 (nibble [3:0]).
module S4_box_dec
  import hb_pkg::*;
(
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);
  assign nib_out = S4_INV[nib_in];
endmodule

// File: rtl/linear_transform_dec.sv
// Inverse of the encrypt-side linear layer L(x) = x ^ (x<<<6) ^ (x<<<10).
// Over GF(2)[x]/(x^16+1) the inverse polynomial is 1 + x^2 + x^4 + x^12 + x^14,
// i.e. the XOR of the input with its rotations left by 2, 4, 12 and 14.
module linear_transform_dec (
  input  logic [15:0] x_in,
  output logic [15:0] x_out
);
  assign x_out = x_in
               ^ {x_in[13:0], x_in[15:14]}
               ^ {x_in[11:0], x_in[15:12]}
               ^ {x_in[3:0],  x_in[15:4]}
               ^ {x_in[1:0],  x_in[15:2]};
endmodule

// File: rtl/hb_decryption_core.sv
// Iterative Hummingbird 16-bit block decryptor: one inverse round per clock,
// sharing a single xor / Linv / Sinv stage across all rounds.
// Optional feature macro: HB_DEC_STATUS_EN adds the CNT_W parameter and the
// blk_cnt completed-block counter port.
module hb_decryption_core
  import hb_pkg::*;
`ifdef HB_DEC_STATUS_EN
#(
  parameter int CNT_W = 16
)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] data_in,
  input  logic [63:0] key_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] data_out
`ifdef HB_DEC_STATUS_EN
  ,
  output logic [CNT_W-1:0] blk_cnt
`endif
);

  hb_state_e        fsm_q, fsm_d;
  logic [15:0]      y_q;
  logic [RND_W-1:0] rnd_q;
  logic [63:0]      key_q;

  logic [15:0] k1, k2, k3, k4;
  logic [15:0] rk;
  logic [15:0] x_in, l_out, s_in, s_out;

  assign k1 = key_word(key_q, K1_LSB);
  assign k2 = key_word(key_q, K2_LSB);
  assign k3 = key_word(key_q, K3_LSB);
  assign k4 = key_word(key_q, K4_LSB);

  // State register for the control FSM.
  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  // Next-state and handshake outputs decoded from the current state.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    fsm_d     = fsm_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_d = ROUND;
      end
      ROUND: begin
        if (rnd_q == LAST_RND) fsm_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Round key schedule {K1^K3, K4, K3, K2} indexed by the round counter.
  always_comb begin
    rk = k2;
    case (rnd_q)
      2'd0:    rk = k1 ^ k3;
      2'd1:    rk = k4;
      2'd2:    rk = k3;
      default: rk = k2;
    endcase
  end

  // Stage input: whitening of the fresh ciphertext in IDLE, round xor otherwise.
  always_comb begin
    if (fsm_q == IDLE) x_in = data_in ^ key_word(key_in, K2_LSB) ^ key_word(key_in, K4_LSB);
    else               x_in = y_q ^ rk;
  end

  linear_transform_dec u_linv (
    .x_in  (x_in),
    .x_out (l_out)
  );

  // The initial step y0 skips the linear layer; all rounds go through it.
  assign s_in = (fsm_q == IDLE) ? x_in : l_out;

  S1_box_dec u_s1 (.nib_in(s_in[15:12]), .nib_out(s_out[15:12]));
  S2_box_dec u_s2 (.nib_in(s_in[11:8]),  .nib_out(s_out[11:8]));
  S3_box_dec u_s3 (.nib_in(s_in[7:4]),   .nib_out(s_out[7:4]));
  S4_box_dec u_s4 (.nib_in(s_in[3:0]),   .nib_out(s_out[3:0]));

  // Datapath: latch key and y0 on accept, iterate rounds, publish the plaintext.
  // NOTE: the key and state registers are plain flops, so they are cleared by reset
  // like the rest; an aborted block therefore leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q      <= '0;
      rnd_q    <= '0;
      key_q    <= '0;
      data_out <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            key_q <= key_in;
            y_q   <= s_out;
            rnd_q <= '0;
          end
        end
        ROUND: begin
          y_q   <= s_out;
          rnd_q <= rnd_q + 1'b1;
          if (rnd_q == LAST_RND) data_out <= s_out ^ k1;
        end
        default: ;
      endcase
    end
  end

`ifdef HB_DEC_STATUS_EN
  // Completed-block counter, advancing on each output handshake and wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       blk_cnt <= '0;
    else if (out_valid && out_ready)  blk_cnt <= blk_cnt + 1'b1;
  end
`endif

endmodule
